// File: rtl/bram_mac_sequencer.sv
// bram_mac_sequencer: walks a job of up to 16 taps through an operand BRAM and a
// coefficient ROM, hands each operand/coefficient pair to an external shift-add
// multiplier and accumulates the two lane products into signed results.
module bram_mac_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int COEF_AW = 6,
    parameter int ACC_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COEF_AW-1:0] coef_base,
    input  logic [4:0]         num_taps,
    output logic               busy,
    output logic               opr_en,
    output logic [ADDR_W-1:0]  opr_addr,
    input  logic [15:0]        opr_data,
    output logic               coef_en,
    output logic [COEF_AW-1:0] coef_addr,
    input  logic [5:0]         coef_data,
    output logic [15:0]        mult_operand,
    output logic [5:0]         mult_coeff,
    input  logic [15:0]        mult_a,
    input  logic [15:0]        mult_b,
    input  logic               mult_sign,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_a,
    output logic [ACC_W-1:0]   res_b
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [4:0] tap_cnt_reg;     // taps still to issue, including the current one
    logic       drain_cnt_reg;   // second DRAIN cycle marker
    logic       rd_valid_reg;    // BRAM/ROM data is on opr_data/coef_data this cycle
    logic       mult_valid_reg;  // mult_operand/mult_coeff hold a live tap

    // A job is accepted only from IDLE; this also clears the accumulators.
    logic accept;
    assign accept = (state_reg == IDLE) && start;

    // Control FSM: sequencing, read enables, address walk and result handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            opr_en        <= 1'b0;
            coef_en       <= 1'b0;
            opr_addr      <= '0;
            coef_addr     <= '0;
            res_valid     <= 1'b0;
            tap_cnt_reg   <= '0;
            drain_cnt_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_taps != 5'd0) begin
                            // Addresses are only loaded for a real job so that a
                            // zero-tap job leaves the address outputs untouched.
                            state_reg   <= ISSUE;
                            opr_en      <= 1'b1;
                            coef_en     <= 1'b1;
                            opr_addr    <= base_addr;
                            coef_addr   <= coef_base;
                            tap_cnt_reg <= num_taps;
                        end else begin
                            state_reg <= DONE;
                            res_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (tap_cnt_reg == 5'd1) begin
                        // Last tap: stop reading and keep the final address.
                        state_reg     <= DRAIN;
                        opr_en        <= 1'b0;
                        coef_en       <= 1'b0;
                        drain_cnt_reg <= 1'b0;
                    end else begin
                        tap_cnt_reg <= tap_cnt_reg - 5'd1;
                        opr_addr    <= opr_addr + 1'b1;
                        coef_addr   <= coef_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // Two cycles cover the read latency and the operand register.
                    if (drain_cnt_reg) begin
                        state_reg <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: capture returned data into the multiplier input registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_reg   <= 1'b0;
            mult_valid_reg <= 1'b0;
            mult_operand   <= '0;
            mult_coeff     <= '0;
        end else begin
            rd_valid_reg   <= opr_en;
            mult_valid_reg <= rd_valid_reg;
            if (rd_valid_reg) begin
                mult_operand <= opr_data;
                mult_coeff   <= coef_data;
            end
        end
    end

    // Per-lane accumulators; lane 0 takes mult_a, lane 1 takes mult_b.
    logic [1:0][15:0]      lane_prod;
    logic [1:0][ACC_W-1:0] res_lane;

    assign lane_prod[0] = mult_a;
    assign lane_prod[1] = mult_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [ACC_W-1:0] acc_reg;
            logic [ACC_W-1:0] prod_ext;

            assign prod_ext = ACC_W'(lane_prod[gi]);

            // Wrapping add/subtract of the zero-extended product for live taps.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= '0;
                end else if (mult_valid_reg) begin
                    acc_reg <= mult_sign ? (acc_reg - prod_ext) : (acc_reg + prod_ext);
                end
            end

            assign res_lane[gi] = acc_reg;
        end
    endgenerate

    // Accumulators are idle in DONE, so they serve directly as the results.
    assign res_a = res_lane[0];
    assign res_b = res_lane[1];

endmodule

// File: tb/tb_bram_mac_sequencer.sv
// Directed bench for bram_mac_sequencer with BRAM/ROM models and a shift-add
// multiplier. Coefficient code {c4,c3,s[2:0]}: s=0 gives 0, otherwise
// 2^(s-1) + (c4 ? 2^s : 0) + (c3 ? 1 : 0); bit 5 of the coefficient is the sign.
module tb_bram_mac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [5:0]  coef_base;
    logic [4:0]  num_taps;
    logic        busy;
    logic        opr_en;
    logic [8:0]  opr_addr;
    logic [15:0] opr_data;
    logic        coef_en;
    logic [5:0]  coef_addr;
    logic [5:0]  coef_data;
    logic [15:0] mult_operand;
    logic [5:0]  mult_coeff;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic        mult_sign;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_a;
    logic [23:0] res_b;

    int total = 0;
    int bad   = 0;

    logic [15:0] opr_mem  [512];
    logic [5:0]  coef_mem [64];

    bram_mac_sequencer #(.ADDR_W(9), .COEF_AW(6), .ACC_W(24)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .coef_base    (coef_base),
        .num_taps     (num_taps),
        .busy         (busy),
        .opr_en       (opr_en),
        .opr_addr     (opr_addr),
        .opr_data     (opr_data),
        .coef_en      (coef_en),
        .coef_addr    (coef_addr),
        .coef_data    (coef_data),
        .mult_operand (mult_operand),
        .mult_coeff   (mult_coeff),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_sign    (mult_sign),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_a        (res_a),
        .res_b        (res_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand BRAM and coefficient ROM with one-cycle registered read.
    always @(posedge clk) begin
        if (opr_en)  opr_data  <= opr_mem[opr_addr];
        if (coef_en) coef_data <= coef_mem[coef_addr];
    end

    function automatic logic [8:0] coef_val(input logic [4:0] code);
        logic [8:0] v;
        int s;
        s = int'(code[2:0]);
        if (s == 0) return 9'd0;
        v = 9'd1 << (s - 1);
        if (code[4]) v = v + (9'd1 << s);
        if (code[3]) v = v + 9'd1;
        return v;
    endfunction

    // Shift-add multiplier: both lanes scaled by the same coefficient.
    logic [8:0] cv;
    always_comb cv = coef_val(mult_coeff[4:0]);
    assign mult_a    = {8'd0, mult_operand[15:8]} * {7'd0, cv};
    assign mult_b    = {8'd0, mult_operand[7:0]}  * {7'd0, cv};
    assign mult_sign = mult_coeff[5];

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a sample point; returns at the sample point of cycle k+1.
    task automatic launch(input logic [8:0] b, input logic [5:0] cb, input logic [4:0] n);
        base_addr = b;
        coef_base = cb;
        num_taps  = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++;
        if ({busy, opr_en, coef_en, res_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000", {busy, opr_en, coef_en, res_valid});
        end
        total++;
        if (opr_addr !== 9'h000 || coef_addr !== 6'h00) begin
            bad++;
            $display("FAIL reset_addr got=%h/%h want=000/00", opr_addr, coef_addr);
        end
        total++;
        if (mult_operand !== 16'h0 || mult_coeff !== 6'h0 || res_a !== 24'h0 || res_b !== 24'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h/%h want=0", mult_operand, mult_coeff, res_a, res_b);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // S1 timing and result; reused after the mid-job reset.
    task automatic test_single(input string tag);
        opr_mem[9'h010]  = 16'h0305;
        coef_mem[6'h02]  = 6'b010001;
        launch(9'h010, 6'h02, 5'd1);
        total++;
        if ({busy, opr_en, coef_en} !== 3'b111 || opr_addr !== 9'h010 || coef_addr !== 6'h02) begin
            bad++;
            $display("FAIL %s_issue got=%b %h %h want=111 010 02", tag, {busy, opr_en, coef_en}, opr_addr, coef_addr);
        end
        tick();
        total++;
        if ({opr_en, coef_en, res_valid} !== 3'b000 || opr_addr !== 9'h010) begin
            bad++;
            $display("FAIL %s_k2 got=%b %h want=000 010", tag, {opr_en, coef_en, res_valid}, opr_addr);
        end
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_k3_valid got=%b want=0", tag, res_valid);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_a !== 24'd9 || res_b !== 24'd15) begin
            bad++;
            $display("FAIL %s_result got=%b %h %h want=1 000009 00000f", tag, res_valid, res_a, res_b);
        end
        $display("job %s n=1 res_a=%h res_b=%h", tag, res_a, res_b);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_transfer got=%b%b want=00", tag, res_valid, busy);
        end
    endtask

    task automatic test_signed_sum();
        opr_mem[9'h020] = 16'h0A01;
        opr_mem[9'h021] = 16'h0402;
        coef_mem[6'h04] = 6'b000001;
        coef_mem[6'h05] = 6'b100110;
        launch(9'h020, 6'h04, 5'd2);
        total++;
        if (opr_en !== 1'b1 || opr_addr !== 9'h020 || coef_addr !== 6'h04) begin
            bad++;
            $display("FAIL s2_tap0 got=%b %h %h want=1 020 04", opr_en, opr_addr, coef_addr);
        end
        tick();
        total++;
        if (opr_en !== 1'b1 || opr_addr !== 9'h021 || coef_addr !== 6'h05) begin
            bad++;
            $display("FAIL s2_tap1 got=%b %h %h want=1 021 05", opr_en, opr_addr, coef_addr);
        end
        tick();
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL s2_early_valid got=%b want=0", res_valid);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_a !== 24'hFFFF8A || res_b !== 24'hFFFFC1) begin
            bad++;
            $display("FAIL s2_result got=%b %h %h want=1 ffff8a ffffc1", res_valid, res_a, res_b);
        end
        $display("job s2 n=2 res_a=%h res_b=%h", res_a, res_b);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_zero_backpressure();
        launch(9'h0AA, 6'h3F, 5'd0);
        total++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || res_a !== 24'h0 || res_b !== 24'h0) begin
            bad++;
            $display("FAIL s3_k1 got=%b%b %h %h want=11 0 0", res_valid, busy, res_a, res_b);
        end
        total++;
        if (opr_en !== 1'b0 || coef_en !== 1'b0 || opr_addr !== 9'h021 || coef_addr !== 6'h05) begin
            bad++;
            $display("FAIL s3_addr_hold got=%b%b %h %h want=00 021 05", opr_en, coef_en, opr_addr, coef_addr);
        end
        $display("job s3 n=0 res_a=%h res_b=%h", res_a, res_b);
        for (int i = 0; i < 5; i++) begin
            start    = (i % 2 == 0);
            num_taps = 5'd3;
            tick();
            total++;
            if ({res_valid, busy, opr_en} !== 3'b110 || res_a !== 24'h0 || res_b !== 24'h0) begin
                bad++;
                $display("FAIL s3_hold%0d got=%b %h %h want=110 0 0", i, {res_valid, busy, opr_en}, res_a, res_b);
            end
        end
        // Start together with the transfer must be ignored.
        start     = 1'b1;
        num_taps  = 5'd1;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        total++;
        if ({res_valid, busy, opr_en} !== 3'b000) begin
            bad++;
            $display("FAIL s3_transfer got=%b want=000", {res_valid, busy, opr_en});
        end
        tick();
        total++;
        if ({busy, opr_en} !== 2'b00) begin
            bad++;
            $display("FAIL s3_start_ignored got=%b want=00", {busy, opr_en});
        end
    endtask

    task automatic test_wrap_full();
        logic [8:0] exp_a;
        logic [5:0] exp_c;
        exp_a = 9'h1FA;
        exp_c = 6'h10;
        for (int i = 0; i < 16; i++) begin
            opr_mem[exp_a]  = 16'hFFFF;
            coef_mem[exp_c] = 6'b011101;
            exp_a++;
            exp_c++;
        end
        launch(9'h1FA, 6'h10, 5'd16);
        exp_a = 9'h1FA;
        exp_c = 6'h10;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({opr_en, coef_en} !== 2'b11 || opr_addr !== exp_a || coef_addr !== exp_c) begin
                bad++;
                $display("FAIL s4_tap%0d got=%b %h %h want=11 %h %h", i, {opr_en, coef_en}, opr_addr, coef_addr, exp_a, exp_c);
            end
            exp_a++;
            exp_c++;
            tick();
        end
        total++;
        if ({opr_en, coef_en, res_valid} !== 3'b000 || opr_addr !== 9'h009 || coef_addr !== 6'h1F) begin
            bad++;
            $display("FAIL s4_after got=%b %h %h want=000 009 1f", {opr_en, coef_en, res_valid}, opr_addr, coef_addr);
        end
        tick();
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL s4_early_valid got=%b want=0", res_valid);
        end
        tick();
        total++;
        if (res_valid !== 1'b1 || res_a !== 24'd199920 || res_b !== 24'd199920) begin
            bad++;
            $display("FAIL s4_result got=%b %0d %0d want=1 199920 199920", res_valid, res_a, res_b);
        end
        $display("job s4 n=16 res_a=%0d res_b=%0d", res_a, res_b);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        for (int i = 0; i < 8; i++) begin
            opr_mem[9'h040 + i] = 16'h1111;
            coef_mem[6'h20 + i] = 6'b000001;
        end
        launch(9'h040, 6'h20, 5'd8);
        tick();
        tick();
        tick();
        total++;
        if (opr_en !== 1'b1 || opr_addr !== 9'h043) begin
            bad++;
            $display("FAIL s5_tap3 got=%b %h want=1 043", opr_en, opr_addr);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({busy, opr_en, coef_en, res_valid} !== 4'b0000 || opr_addr !== 9'h0 || coef_addr !== 6'h0) begin
            bad++;
            $display("FAIL s5_ctrl got=%b %h %h want=0000 000 00", {busy, opr_en, coef_en, res_valid}, opr_addr, coef_addr);
        end
        total++;
        if (mult_operand !== 16'h0 || mult_coeff !== 6'h0 || res_a !== 24'h0 || res_b !== 24'h0) begin
            bad++;
            $display("FAIL s5_data got=%h %h %h %h want=0", mult_operand, mult_coeff, res_a, res_b);
        end
        tick();
        tick();
        total++;
        if ({busy, opr_en, coef_en, res_valid} !== 4'b0000 || res_a !== 24'h0) begin
            bad++;
            $display("FAIL s5_quiet got=%b %h want=0000 0", {busy, opr_en, coef_en, res_valid}, res_a);
        end
        test_single("s5");
    endtask

    task automatic test_back_to_back();
        logic [8:0]  jb [3] = '{9'h010, 9'h020, 9'h080};
        logic [5:0]  jc [3] = '{6'h02, 6'h04, 6'h30};
        logic [4:0]  jn [3] = '{5'd1, 5'd2, 5'd3};
        logic [23:0] ja [3] = '{24'd9, 24'hFFFF8A, 24'd5};
        logic [23:0] jr [3] = '{24'd15, 24'hFFFFC1, 24'd8};
        int cyc;
        int issues;
        opr_mem[9'h080] = 16'h0102;
        opr_mem[9'h081] = 16'h0304;
        opr_mem[9'h082] = 16'h0506;
        coef_mem[6'h30] = 6'b000001;
        coef_mem[6'h31] = 6'b010001;
        coef_mem[6'h32] = 6'b100001;
        res_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            launch(jb[j], jc[j], jn[j]);
            total++;
            if (opr_en !== 1'b1 || opr_addr !== jb[j]) begin
                bad++;
                $display("FAIL s6_job%0d_first got=%b %h want=1 %h", j, opr_en, opr_addr, jb[j]);
            end
            cyc    = 1;
            issues = 0;
            while (res_valid !== 1'b1 && cyc < 40) begin
                if (opr_en === 1'b1) issues++;
                tick();
                cyc++;
            end
            total++;
            if (cyc != int'(jn[j]) + 3 || issues != int'(jn[j])) begin
                bad++;
                $display("FAIL s6_job%0d_timing got=cyc%0d iss%0d want=cyc%0d iss%0d", j, cyc, issues, int'(jn[j]) + 3, jn[j]);
            end
            total++;
            if (res_a !== ja[j] || res_b !== jr[j]) begin
                bad++;
                $display("FAIL s6_job%0d_result got=%h %h want=%h %h", j, res_a, res_b, ja[j], jr[j]);
            end
            $display("job s6.%0d n=%0d res_a=%h res_b=%h", j, jn[j], res_a, res_b);
            tick();
            total++;
            if ({res_valid, busy} !== 2'b00) begin
                bad++;
                $display("FAIL s6_job%0d_transfer got=%b want=00", j, {res_valid, busy});
            end
        end
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) opr_mem[i] = 16'h0;
        for (int i = 0; i < 64; i++) coef_mem[i] = 6'h0;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        base_addr = 9'h0;
        coef_base = 6'h0;
        num_taps  = 5'd0;
        test_reset();
        test_single("s1");
        test_signed_sum();
        test_zero_backpressure();
        test_wrap_full();
        test_reset_mid_job();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
